vga_timing_gen: RTL and testbench

Display timing generator for the 1440×900 @ 60 Hz VGA output. It drives the pixel coordinates that the draw controller consumes, and captures that controller's RGB answer. It then emits the RGB pixel, hsync and vsync to the pins, aligned to compensate for the draw controller's pipeline latency. It also provides a once-per-frame tick for game-state update logic.

---
 rtl/vga_timing_gen_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared display timing definitions for the 1440x900 @ 60 Hz raster.
// The draw controller imports the colour and coordinate types from here too.
package vga_timing_pkg;

  typedef logic [3:0]  color_t;
  typedef logic [10:0] coord_t;

  localparam int unsigned VGA_H_ACTIVE = 1440;
  localparam int unsigned VGA_H_FP     = 80;
  localparam int unsigned VGA_H_SYNC   = 152;
  localparam int unsigned VGA_H_BP     = 232;

  localparam int unsigned VGA_V_ACTIVE = 900;
  localparam int unsigned VGA_V_FP     = 1;
  localparam int unsigned VGA_V_SYNC   = 3;
  localparam int unsigned VGA_V_BP     = 28;

  localparam bit VGA_H_SYNC_POL = 1'b0;
  localparam bit VGA_V_SYNC_POL = 1'b1;

  localparam int unsigned VGA_DRAW_LATENCY     = 1;
  localparam int unsigned VGA_MAX_DRAW_LATENCY = 4;

  // Every timing sum has to fit the 11-bit coordinate type.
  localparam int unsigned VGA_COORD_LIMIT = 2048;

  function automatic int unsigned h_total(input int unsigned a_active, input int unsigned a_fp,
                                          input int unsigned a_sync, input int unsigned a_bp);
    return a_active + a_fp + a_sync + a_bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned a_active, input int unsigned a_fp,
                                          input int unsigned a_sync, input int unsigned a_bp);
    return a_active + a_fp + a_sync + a_bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the timing generator, the draw controller and the pin side.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  color_t draw_r;
  color_t draw_g;
  color_t draw_b;
  coord_t curr_x;
  coord_t curr_y;
  color_t pix_r;
  color_t pix_g;
  color_t pix_b;
  logic   hsync;
  logic   vsync;
  logic   active;
  logic   frame_tick;

  modport master (
    input  draw_r, draw_g, draw_b,
    output curr_x, curr_y, pix_r, pix_g, pix_b, hsync, vsync, active, frame_tick
  );

  modport slave (
    output draw_r, draw_g, draw_b,
    input  curr_x, curr_y, pix_r, pix_g, pix_b, hsync, vsync, active, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// DEPTH = 0 degenerates to a wire so the caller needs no special case.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per clock; clear wipes every stage so no stale flags survive reset.
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: issues coordinates to the draw controller, then
// re-aligns the returned colour with sync/visible flags at the output pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned H_FP         = VGA_H_FP,
  parameter int unsigned H_SYNC       = VGA_H_SYNC,
  parameter int unsigned H_BP         = VGA_H_BP,
  parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
  parameter int unsigned V_FP         = VGA_V_FP,
  parameter int unsigned V_SYNC       = VGA_V_SYNC,
  parameter int unsigned V_BP         = VGA_V_BP,
  parameter bit          H_SYNC_POL   = VGA_H_SYNC_POL,
  parameter bit          V_SYNC_POL   = VGA_V_SYNC_POL,
  parameter int unsigned DRAW_LATENCY = VGA_DRAW_LATENCY
) (
  input  logic             i_clk,
  input  logic             i_rst,
  vga_timing_gen_if.master io_vga
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t C_H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t C_V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t C_H_ACTIVE   = coord_t'(H_ACTIVE);
  localparam coord_t C_V_ACTIVE   = coord_t'(V_ACTIVE);
  localparam coord_t C_HS_START   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t C_HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t C_VS_START   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t C_VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL >= VGA_COORD_LIMIT || V_TOTAL >= VGA_COORD_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: line or frame total does not fit 11 bits");
  end
  if (DRAW_LATENCY > VGA_MAX_DRAW_LATENCY) begin : g_bad_latency
    $error("vga_timing_gen: DRAW_LATENCY above supported maximum");
  end

  coord_t     r_h_cnt;
  coord_t     r_v_cnt;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_vis;
  logic       w_hs;
  logic       w_vs;
  logic [2:0] w_flags_dly;
  color_t     r_pix_r;
  color_t     r_pix_g;
  color_t     r_pix_b;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_active;
  logic       r_frame_tick;

  assign w_h_wrap = (r_h_cnt == C_H_LAST);
  assign w_v_wrap = (r_v_cnt == C_V_LAST);

  // Raster counters; both wrap on the same edge at the last pixel of the frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + coord_t'(1);
    end else begin
      r_h_cnt <= r_h_cnt + coord_t'(1);
    end
  end

  assign w_vis = (r_h_cnt < C_H_ACTIVE) && (r_v_cnt < C_V_ACTIVE);
  assign w_hs  = (r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END);
  assign w_vs  = (r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END);

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (DRAW_LATENCY)
  ) u_flag_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data ({w_vis, w_hs, w_vs}),
    .o_data (w_flags_dly)
  );

  // Pin register: delayed flags meet the draw colour for the same coordinate.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pix_r  <= '0;
      r_pix_g  <= '0;
      r_pix_b  <= '0;
      r_hsync  <= ~H_SYNC_POL;
      r_vsync  <= ~V_SYNC_POL;
      r_active <= 1'b0;
    end else begin
      r_pix_r  <= w_flags_dly[2] ? io_vga.draw_r : '0;
      r_pix_g  <= w_flags_dly[2] ? io_vga.draw_g : '0;
      r_pix_b  <= w_flags_dly[2] ? io_vga.draw_b : '0;
      r_hsync  <= w_flags_dly[1] ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync  <= w_flags_dly[0] ? V_SYNC_POL : ~V_SYNC_POL;
      r_active <= w_flags_dly[2];
    end
  end

  // Frame tick follows the issued counters, not the pins, so game logic gets the earliest notice.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_frame_tick <= 1'b0;
    else        r_frame_tick <= (r_h_cnt == '0) && (r_v_cnt == C_V_ACTIVE);
  end

  assign io_vga.curr_x     = r_h_cnt;
  assign io_vga.curr_y     = r_v_cnt;
  assign io_vga.pix_r      = r_pix_r;
  assign io_vga.pix_g      = r_pix_g;
  assign io_vga.pix_b      = r_pix_b;
  assign io_vga.hsync      = r_hsync;
  assign io_vga.vsync      = r_vsync;
  assign io_vga.active     = r_active;
  assign io_vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three reduced-raster instances (latency 0, 1, 4, one with
// inverted sync polarities) plus one full-size 1440x900 instance.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NDUT = 4;

  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t r;
    color_t g;
    color_t b;
    logic   hs;
    logic   vs;
    logic   act;
    logic   tick;
  } pins_t;

  int cfg_ha [NDUT] = '{16, 16, 16, 1440};
  int cfg_hfp[NDUT] = '{4, 4, 4, 80};
  int cfg_hs [NDUT] = '{6, 6, 6, 152};
  int cfg_hbp[NDUT] = '{6, 6, 6, 232};
  int cfg_va [NDUT] = '{10, 10, 10, 900};
  int cfg_vfp[NDUT] = '{1, 1, 1, 1};
  int cfg_vs [NDUT] = '{3, 3, 3, 3};
  int cfg_vbp[NDUT] = '{2, 2, 2, 28};
  int cfg_dl [NDUT] = '{0, 1, 4, 1};
  bit cfg_hp [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit cfg_vp [NDUT] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();
  vga_timing_gen_if vif3 ();

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(10), .V_FP(1),
                   .V_SYNC(3), .V_BP(2), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .DRAW_LATENCY(0))
    dut0 (.i_clk(clk), .i_rst(rst), .io_vga(vif0));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(10), .V_FP(1),
                   .V_SYNC(3), .V_BP(2), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .DRAW_LATENCY(1))
    dut1 (.i_clk(clk), .i_rst(rst), .io_vga(vif1));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(10), .V_FP(1),
                   .V_SYNC(3), .V_BP(2), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .DRAW_LATENCY(4))
    dut2 (.i_clk(clk), .i_rst(rst), .io_vga(vif2));
  vga_timing_gen dut3 (.i_clk(clk), .i_rst(rst), .io_vga(vif3));

  pins_t       got [NDUT];
  logic [11:0] drw [NDUT];

  assign got[0] = {vif0.curr_x, vif0.curr_y, vif0.pix_r, vif0.pix_g, vif0.pix_b,
                   vif0.hsync, vif0.vsync, vif0.active, vif0.frame_tick};
  assign got[1] = {vif1.curr_x, vif1.curr_y, vif1.pix_r, vif1.pix_g, vif1.pix_b,
                   vif1.hsync, vif1.vsync, vif1.active, vif1.frame_tick};
  assign got[2] = {vif2.curr_x, vif2.curr_y, vif2.pix_r, vif2.pix_g, vif2.pix_b,
                   vif2.hsync, vif2.vsync, vif2.active, vif2.frame_tick};
  assign got[3] = {vif3.curr_x, vif3.curr_y, vif3.pix_r, vif3.pix_g, vif3.pix_b,
                   vif3.hsync, vif3.vsync, vif3.active, vif3.frame_tick};

  assign {vif0.draw_r, vif0.draw_g, vif0.draw_b} = drw[0];
  assign {vif1.draw_r, vif1.draw_g, vif1.draw_b} = drw[1];
  assign {vif2.draw_r, vif2.draw_g, vif2.draw_b} = drw[2];
  assign {vif3.draw_r, vif3.draw_g, vif3.draw_b} = drw[3];

  color_t ctab [256];
  pins_t  expq [NDUT][$];
  int     hx [NDUT][5];
  int     hy [NDUT][5];
  int     n_cyc = -1;
  int     n_tests = 0;
  int     n_fail = 0;

  // Picture content seen by the draw controller model: random per coordinate.
  function automatic color_t color(input int x, input int y, input int ch);
    return ctab[(x * 3 + y * 5 + ch * 85) & 255];
  endfunction

  // Expected pins for cycle n after reset, from raster arithmetic on the cycle count.
  function automatic pins_t model(input int k, input int n);
    pins_t e;
    int ht, vt, m, ph, pv;
    ht = cfg_ha[k] + cfg_hfp[k] + cfg_hs[k] + cfg_hbp[k];
    vt = cfg_va[k] + cfg_vfp[k] + cfg_vs[k] + cfg_vbp[k];
    e.x    = coord_t'(n % ht);
    e.y    = coord_t'((n / ht) % vt);
    e.r    = '0;
    e.g    = '0;
    e.b    = '0;
    e.act  = 1'b0;
    e.hs   = ~cfg_hp[k];
    e.vs   = ~cfg_vp[k];
    m = n - cfg_dl[k] - 1;
    if (m >= 0) begin
      ph = m % ht;
      pv = (m / ht) % vt;
      if (ph < cfg_ha[k] && pv < cfg_va[k]) begin
        e.act = 1'b1;
        e.r   = color(ph, pv, 0);
        e.g   = color(ph, pv, 1);
        e.b   = color(ph, pv, 2);
      end
      if (ph >= cfg_ha[k] + cfg_hfp[k] && ph < cfg_ha[k] + cfg_hfp[k] + cfg_hs[k])
        e.hs = cfg_hp[k];
      if (pv >= cfg_va[k] + cfg_vfp[k] && pv < cfg_va[k] + cfg_vfp[k] + cfg_vs[k])
        e.vs = cfg_vp[k];
    end
    e.tick = (n >= 1) && (((n - 1) % ht) == 0) && ((((n - 1) / ht) % vt) == cfg_va[k]);
    return e;
  endfunction

  // One clock: drive rst for the next edge, then after the edge update the
  // draw controller model and queue the expected pin state for this cycle.
  task automatic step(input logic rst_val);
    int d;
    rst = rst_val;
    @(posedge clk);
    #1;
    if (!rst_val) n_cyc = 0;
    else if (n_cyc >= 0) n_cyc++;
    for (int k = 0; k < NDUT; k++) begin
      for (int j = 4; j > 0; j--) begin
        hx[k][j] = hx[k][j-1];
        hy[k][j] = hy[k][j-1];
      end
      hx[k][0] = int'(got[k].x);
      hy[k][0] = int'(got[k].y);
      d = cfg_dl[k];
      drw[k] = {color(hx[k][d], hy[k][d], 0), color(hx[k][d], hy[k][d], 1),
                color(hx[k][d], hy[k][d], 2)};
      if (n_cyc >= 0) expq[k].push_back(model(k, n_cyc));
    end
  endtask

  task automatic segment(input int rst_cycles, input int run_cycles);
    repeat (rst_cycles) step(1'b0);
    repeat (run_cycles) step(1'b1);
  endtask

  // Monitor: every cycle each instance presents a pin state; pop and compare.
  always @(negedge clk) begin : monitor
    pins_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (expq[k].size() > 0) begin
        e = expq[k].pop_front();
        n_tests++;
        if (got[k] !== e) begin
          n_fail++;
          $display("FAIL pins dut%0d t=%0t got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b act=%b tick=%b want x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b act=%b tick=%b",
                   k, $time, got[k].x, got[k].y, got[k].r, got[k].g, got[k].b, got[k].hs,
                   got[k].vs, got[k].act, got[k].tick, e.x, e.y, e.r, e.g, e.b, e.hs, e.vs,
                   e.act, e.tick);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ctab[i] = color_t'($urandom_range(1, 15));
    for (int k = 0; k < NDUT; k++) begin
      drw[k] = '0;
      for (int j = 0; j < 5; j++) begin
        hx[k][j] = 0;
        hy[k][j] = 0;
      end
    end
    segment(3, 4500);
    for (int i = 0; i < 4; i++) segment($urandom_range(1, 3), $urandom_range(600, 1500));
    @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      n_tests++;
      if (expq[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain dut%0d leftover=%0d want 0", k, expq[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
